// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file.
//  - XLEN-bit entries, NREG registers (power of 2), NRD combinational read
//    ports, NWR write ports.
//  - x0 is hardwired to zero. Writes to it are dropped.
//  - Same-cycle write-to-read bypass. When several write ports target the
//    same register, the highest-index enabled port wins, for both the stored
//    value and the bypass.
//  - Optional busy-bit scoreboard, enabled by defining
//    REGFILE_MP_SCOREBOARD_EN.
//    - When the macro is undefined, iss_valid/iss_addr are ignored.
//    - When the macro is undefined, rd_busy is constant 0.
//  - Handshake note: there is no valid/ready pairing here. Writes are
//    qualified only by wr_en. Issue is qualified only by iss_valid. The file
//    never stalls. The issue stage is responsible for not issuing a reader
//    while rd_busy is high.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 1,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  output logic [NRD-1:0]      rd_busy
);

  // Entry 0 is never written, so it keeps its reset value of zero.
  logic [XLEN-1:0] mem [NREG];

  // Register writes. Later loop iterations override earlier ones, which
  // gives the highest-index port priority on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) mem[k] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_en[i] && (wr_addr[i*AW +: AW] != '0))
          mem[wr_addr[i*AW +: AW]] <= wr_data[i*XLEN +: XLEN];
      end
    end
  end

`ifdef REGFILE_MP_SCOREBOARD_EN
  logic [NREG-1:0] busy;

  // Busy bits. Retiring writes clear first, then a new issue sets. When both
  // hit the same register in one cycle, the new producer wins. Bit 0 is
  // never set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_en[i]) busy[wr_addr[i*AW +: AW]] <= 1'b0;
      end
      if (iss_valid && (iss_addr != '0)) busy[iss_addr] <= 1'b1;
    end
  end
`else
  logic unused_iss;
  assign unused_iss = ^{iss_valid, iss_addr};
`endif

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            hit;
    logic [XLEN-1:0] bval;

    assign ra = rd_addr[r*AW +: AW];

    // Bypass search across write ports; highest enabled matching port wins.
    always_comb begin
      hit  = 1'b0;
      bval = '0;
      for (int i = 0; i < NWR; i++) begin
        if (wr_en[i] && (wr_addr[i*AW +: AW] == ra)) begin
          hit  = 1'b1;
          bval = wr_data[i*XLEN +: XLEN];
        end
      end
    end

    // Outputs are forced to zero while reset is held, even if a write
    // enable is asserted at the same time.
    assign rd_data[r*XLEN +: XLEN] = (!rst_n || (ra == '0)) ? '0 :
                                     hit ? bval : mem[ra];

`ifdef REGFILE_MP_SCOREBOARD_EN
    assign rd_busy[r] = rst_n && busy[ra] && !hit;
`else
    assign rd_busy[r] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random checks of regfile_mp.
//  - Instance a: 32x32, 2 read ports, 2 write ports.
//  - Instance b: 16x64, 3 read ports, 1 write port.
module tb_regfile_mp;

  logic clk;
  logic rst_n;

  // ---------------- instance a: XLEN=32 NREG=32 NRD=2 NWR=2 ----------------
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [1:0]  rd_busy;

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .rd_busy(rd_busy)
  );

  // ---------------- instance b: XLEN=64 NREG=16 NRD=3 NWR=1 ----------------
  logic [0:0]   wr_en_b;
  logic [3:0]   wr_addr_b;
  logic [63:0]  wr_data_b;
  logic [11:0]  rd_addr_b;
  logic [191:0] rd_data_b;
  logic         iss_valid_b;
  logic [3:0]   iss_addr_b;
  logic [2:0]   rd_busy_b;

  regfile_mp #(.XLEN(64), .NREG(16), .NRD(3), .NWR(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .iss_valid(iss_valid_b), .iss_addr(iss_addr_b), .rd_busy(rd_busy_b)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [31:0] model [32];
  logic        busy_m [32];
  logic [31:0] exp_q[$];
  logic        exp_bq[$];
  logic [63:0] exp_q64[$];
  int checks;
  int errors;

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    logic [31:0] v;
    if (!rst_n || a == 5'd0) return 32'h0;
    v = model[a];
    for (int p = 0; p < 2; p++)
      if (wr_en[p] && wr_addr[p*5 +: 5] == a) v = wr_data[p*32 +: 32];
    return v;
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
`ifdef REGFILE_MP_SCOREBOARD_EN
    logic b;
    if (!rst_n) return 1'b0;
    b = busy_m[a];
    for (int p = 0; p < 2; p++)
      if (wr_en[p] && wr_addr[p*5 +: 5] == a) b = 1'b0;
    return b;
`else
    return a == 5'd31 && 1'b0;
`endif
  endfunction

  function automatic logic [63:0] walk_val(input int k);
    return (k == 0) ? 64'h0 : (64'd1 << (k*4 + 3));
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 32; k++) begin
      model[k]  = 32'h0;
      busy_m[k] = 1'b0;
    end
  endtask

  task automatic wr_port(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en[p]           = 1'b1;
    wr_addr[p*5 +: 5]  = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic rd_both(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr[4:0] = a0;
    rd_addr[9:5] = a1;
  endtask

  // Clock edge on instance a: the model absorbs what the bench drove.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        if (wr_en[p] && wr_addr[p*5 +: 5] != 5'd0)
          model[wr_addr[p*5 +: 5]] = wr_data[p*32 +: 32];
        if (wr_en[p]) busy_m[wr_addr[p*5 +: 5]] = 1'b0;
      end
      if (iss_valid && iss_addr != 5'd0) busy_m[iss_addr] = 1'b1;
    end
    #1;
    wr_en     = 2'b00;
    iss_valid = 1'b0;
  endtask

  // Push expectations for the current inputs, settle, then pop and compare.
  task automatic check_a(input string tag);
    logic [31:0] e;
    logic        eb;
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(exp_read(rd_addr[p*5 +: 5]));
      exp_bq.push_back(exp_busy(rd_addr[p*5 +: 5]));
    end
    #1;
    for (int p = 0; p < 2; p++) begin
      e  = exp_q.pop_front();
      eb = exp_bq.pop_front();
      checks++;
      assert (rd_data[p*32 +: 32] === e) else begin
        errors++;
        $error("FAIL %s rd_data[%0d] got %h exp %h", tag, p, rd_data[p*32 +: 32], e);
      end
      checks++;
      assert (rd_busy[p] === eb) else begin
        errors++;
        $error("FAIL %s rd_busy[%0d] got %b exp %b", tag, p, rd_busy[p], eb);
      end
    end
  endtask

  task automatic check_b(input string tag);
    logic [63:0] e;
    for (int p = 0; p < 3; p++) exp_q64.push_back(walk_val(int'(rd_addr_b[p*4 +: 4])));
    #1;
    for (int p = 0; p < 3; p++) begin
      e = exp_q64.pop_front();
      checks++;
      assert (rd_data_b[p*64 +: 64] === e) else begin
        errors++;
        $error("FAIL %s b rd_data[%0d] got %h exp %h", tag, p, rd_data_b[p*64 +: 64], e);
      end
    end
    checks++;
    assert (rd_busy_b === 3'b000) else begin
      errors++;
      $error("FAIL %s b rd_busy got %b exp 000", tag, rd_busy_b);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks = 0;
    errors = 0;
    clear_model();
    rst_n = 1'b0;
    wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    iss_valid = 1'b0; iss_addr = '0;
    wr_en_b = '0; wr_addr_b = '0; wr_data_b = '0; rd_addr_b = '0;
    iss_valid_b = 1'b0; iss_addr_b = '0;

    // reset state
    #12;
    rd_both(5'd5, 5'd31);
    check_a("reset");
    rst_n = 1'b1;
    tick();

    // write x5, bypass then stored
    wr_port(0, 5'd5, 32'hDEADBEEF);
    rd_both(5'd5, 5'd5);
    check_a("x5_bypass");
    tick();
    check_a("x5_stored");

    // async reset mid-cycle
    #2;
    rst_n = 1'b0;
    clear_model();
    check_a("async_reset");
    #1;
    rst_n = 1'b1;
    tick();
    check_a("after_reset");

    // x0 writes are dropped, bypass of x0 is zero
    wr_port(0, 5'd0, 32'h1234);
    wr_port(1, 5'd0, 32'h5678);
    rd_both(5'd0, 5'd0);
    check_a("x0_bypass");
    tick();
    check_a("x0_stored");

    // bypass over an older value
    wr_port(0, 5'd7, 32'h11111111);
    tick();
    wr_port(1, 5'd7, 32'hA5A5A5A5);
    rd_both(5'd7, 5'd7);
    check_a("x7_bypass");
    tick();
    check_a("x7_stored");

    // collision: port 1 wins
    wr_port(0, 5'd3, 32'd1);
    wr_port(1, 5'd3, 32'd2);
    rd_both(5'd3, 5'd3);
    check_a("collide_bypass");
    tick();
    check_a("collide_stored");

    // two independent writes
    wr_port(0, 5'd10, 32'hCAFE0010);
    wr_port(1, 5'd11, 32'hCAFE0011);
    rd_both(5'd10, 5'd11);
    check_a("dual_bypass");
    tick();
    check_a("dual_stored");

    // scoreboard
    iss_valid = 1'b1; iss_addr = 5'd9;
    tick();
    rd_both(5'd9, 5'd0);
    check_a("sb_busy_set");
    wr_port(0, 5'd9, 32'h99);
    check_a("sb_write_bypass");
    tick();
    check_a("sb_cleared");
    iss_valid = 1'b1; iss_addr = 5'd9;
    wr_port(1, 5'd9, 32'h999);
    tick();
    check_a("sb_set_wins");
    iss_valid = 1'b1; iss_addr = 5'd0;
    tick();
    rd_both(5'd0, 5'd9);
    check_a("sb_x0_never_busy");
    wr_port(0, 5'd9, 32'h9999);
    tick();
    check_a("sb_release");

    // random traffic
    for (int n = 0; n < 24; n++) begin
      wr_en = 2'($urandom_range(0, 3));
      wr_port_rand: for (int p = 0; p < 2; p++) begin
        wr_addr[p*5 +: 5]   = 5'($urandom_range(0, 15));
        wr_data[p*32 +: 32] = $urandom;
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_addr  = 5'($urandom_range(0, 15));
      rd_both(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
      check_a("random");
      tick();
    end

    // instance b: walking ones across every register
    for (int k = 0; k < 16; k++) begin
      wr_en_b   = 1'b1;
      wr_addr_b = 4'(k);
      wr_data_b = (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : walk_val(k);
      @(posedge clk);
      #1;
    end
    wr_en_b = 1'b0;
    for (int k = 0; k < 16; k += 3) begin
      rd_addr_b = {4'((k + 2) % 16), 4'((k + 1) % 16), 4'(k)};
      check_b("walk");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
